// File: rtl/weight_update_writer.sv
// Applies popped weight deltas to the weight RAM by read-modify-write: W[layer][row] <= W - delta.
// Optional build macro WUW_SATURATE_EN clamps each lane on overflow instead of wrapping.
module weight_update_writer #(
  parameter int max_layer_size = 4,
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int layer_count    = 4,
  parameter int addr_width     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      is_update_weight,
  input  logic [31:0]               update_weight_layer,
  input  logic [31:0]               update_weight_row,
  input  logic [size*data_size-1:0] update_weight_value,
  output logic                      read_update_data,
  output logic [addr_width-1:0]     mem_addr,
  output logic                      mem_rd_en,
  input  logic [size*data_size-1:0] mem_rd_data,
  output logic                      mem_wr_en,
  output logic [size*data_size-1:0] mem_wr_data,
  output logic                      busy,
  output logic [15:0]               update_count,
  output logic                      err_range
);

  typedef enum logic [1:0] {IDLE, POP, RDWAIT, WRITE} state_t;

  state_t                    state, state_n;
  logic [size*data_size-1:0] value_q, value_n;
  logic [size*data_size-1:0] wdata_n;
  logic [addr_width-1:0]     addr_n;
  logic [15:0]               cnt_n;
  logic                      pop_n, rd_n, wr_n, err_n, busy_n;
  logic                      in_range;

  function automatic logic [data_size-1:0] lane_sub(input logic [data_size-1:0] a,
                                                    input logic [data_size-1:0] b);
`ifdef WUW_SATURATE_EN
    logic [data_size:0] diff;
    diff = {a[data_size-1], a} - {b[data_size-1], b};
    // Sign-extended result disagreeing in its top two bits means the lane overflowed.
    if (diff[data_size] != diff[data_size-1])
      return diff[data_size] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
    return diff[data_size-1:0];
`else
    return a - b;
`endif
  endfunction

  assign in_range = (update_weight_layer < 32'(layer_count)) &&
                    (update_weight_row < 32'(max_layer_size));

  always_comb begin
    state_n = state;
    value_n = value_q;
    wdata_n = mem_wr_data;
    addr_n  = mem_addr;
    cnt_n   = update_count;
    err_n   = err_range;
    pop_n   = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    case (state)
      IDLE: begin
        addr_n = '0;
        if (is_update_weight) begin
          value_n = update_weight_value;
          pop_n   = 1'b1;
          state_n = POP;
          if (in_range) begin
            rd_n   = 1'b1;
            addr_n = update_weight_layer[addr_width-1:0] * addr_width'(max_layer_size)
                   + update_weight_row[addr_width-1:0];
          end
        end
      end
      // mem_rd_en doubles as the captured in-range flag while in POP.
      POP: begin
        if (mem_rd_en) begin
          state_n = RDWAIT;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      RDWAIT: begin
        for (int unsigned i = 0; i < size; i++)
          wdata_n[i*data_size +: data_size] = lane_sub(mem_rd_data[i*data_size +: data_size],
                                                       value_q[i*data_size +: data_size]);
        wr_n    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        cnt_n   = update_count + 16'd1;
        addr_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      value_q          <= '0;
      read_update_data <= 1'b0;
      mem_addr         <= '0;
      mem_rd_en        <= 1'b0;
      mem_wr_en        <= 1'b0;
      mem_wr_data      <= '0;
      busy             <= 1'b0;
      update_count     <= '0;
      err_range        <= 1'b0;
    end else begin
      state            <= state_n;
      value_q          <= value_n;
      read_update_data <= pop_n;
      mem_addr         <= addr_n;
      mem_rd_en        <= rd_n;
      mem_wr_en        <= wr_n;
      mem_wr_data      <= wdata_n;
      busy             <= busy_n;
      update_count     <= cnt_n;
      err_range        <= err_n;
    end
  end

endmodule

// File: tb/tb_weight_update_writer.sv
// Directed bench for weight_update_writer with a timeline model of each captured update.
module tb_weight_update_writer;
  localparam int W = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          is_update_weight = 1'b0;
  logic [31:0]   update_weight_layer = '0;
  logic [31:0]   update_weight_row = '0;
  logic [W-1:0]  update_weight_value = '0;
  logic          read_update_data;
  logic [3:0]    mem_addr;
  logic          mem_rd_en;
  logic [W-1:0]  mem_rd_data;
  logic          mem_wr_en;
  logic [W-1:0]  mem_wr_data;
  logic          busy;
  logic [15:0]   update_count;
  logic          err_range;

  weight_update_writer #(.max_layer_size(4), .data_size(16), .size(3),
                         .layer_count(4), .addr_width(4)) dut (
    .clk(clk), .rst(rst), .is_update_weight(is_update_weight),
    .update_weight_layer(update_weight_layer), .update_weight_row(update_weight_row),
    .update_weight_value(update_weight_value), .read_update_data(read_update_data),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy),
    .update_count(update_count), .err_range(err_range));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Weight RAM, 1-cycle read latency
  logic [W-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
  end

  // backprop_stack stand-in: head valid while the queue is non-empty
  typedef struct {
    logic [31:0]  layer;
    logic [31:0]  row;
    logic [W-1:0] val;
  } upd_t;
  upd_t q[$];

  always @(negedge clk) begin
    if (read_update_data && q.size() > 0) q.delete(0);
    is_update_weight = (q.size() > 0);
    if (q.size() > 0) begin
      update_weight_layer = q[0].layer;
      update_weight_row   = q[0].row;
      update_weight_value = q[0].val;
    end
  end

  task automatic push(input int l, input int r, input logic [W-1:0] v);
    upd_t u;
    u.layer = l; u.row = r; u.val = v;
    q.push_back(u);
  endtask

  // Reference model
  function automatic logic [15:0] lane_res(input logic [15:0] o, input logic [15:0] d);
    int r;
    r = int'($signed(o)) - int'($signed(d));
`ifdef WUW_SATURATE_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  function automatic logic [W-1:0] row_res(input logic [W-1:0] o, input logic [W-1:0] d);
    logic [W-1:0] res;
    for (int i = 0; i < 3; i++) res[i*16 +: 16] = lane_res(o[i*16 +: 16], d[i*16 +: 16]);
    return res;
  endfunction

  logic [W-1:0] gram [16];
  int           e = 0;
  int           cap_e = 0;
  bit           have = 0;
  bit           inr = 0;
  logic [3:0]   m_addr = '0;
  logic [W-1:0] m_wd = '0;
  logic [15:0]  m_cnt = '0;
  bit           m_err = 0;

  // Capture at edge N: POP in the cycle after edge N, WRITE two cycles later, free at edge N+4.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have = 0; m_cnt = '0; m_err = 0;
    end else begin
      e++;
      if (have && inr && e == cap_e + 3) begin
        m_cnt++;
        gram[m_addr] = m_wd;
      end
      if (have && !inr && e == cap_e + 1) m_err = 1;
      if (is_update_weight && (!have || e >= cap_e + (inr ? 4 : 2))) begin
        have  = 1;
        cap_e = e;
        inr   = (update_weight_layer < 4) && (update_weight_row < 4);
        if (inr) begin
          m_addr = 4'(update_weight_layer * 4 + update_weight_row);
          m_wd   = row_res(gram[m_addr], update_weight_value);
        end else begin
          m_addr = '0;
        end
      end
    end
  end

  int pops = 0, rds = 0, wrs = 0, active = 0;
  int pop_e[$];
  int last_pop_e = 0, last_wr_e = 0;
  logic [3:0] last_pop_addr = '0;

  always @(negedge clk) begin
    int  d;
    bit  live;
    d    = e - cap_e;
    live = have && (inr ? (d >= 0 && d <= 2) : (d == 0));
    chk("busy", W'(busy), W'(live));
    chk("read_update_data", W'(read_update_data), W'(have && d == 0));
    chk("mem_rd_en", W'(mem_rd_en), W'(have && inr && d == 0));
    chk("mem_wr_en", W'(mem_wr_en), W'(have && inr && d == 2));
    chk("mem_addr", W'(mem_addr), W'((live && inr) ? m_addr : 4'd0));
    chk("update_count", W'(update_count), W'(m_cnt));
    chk("err_range", W'(err_range), W'(m_err));
    if (have && inr && d == 2) chk("mem_wr_data", mem_wr_data, m_wd);
    if (read_update_data) begin
      pops++; pop_e.push_back(e); last_pop_e = e; last_pop_addr = mem_addr;
    end
    if (mem_rd_en) rds++;
    if (mem_wr_en) begin wrs++; last_wr_e = e; end
    if (busy || read_update_data || mem_rd_en || mem_wr_en) active++;
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((q.size() > 0 || is_update_weight) && n < 200) begin
      @(negedge clk); n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL %s: timeout waiting for queue drain, got %0d cycles expected < 200", name, n);
    end
    repeat (6) @(negedge clk);
  endtask

  localparam logic [15:0] OVF_EXP =
`ifdef WUW_SATURATE_EN
    16'h7FFF;
`else
    16'hFE00;
`endif
  localparam logic [W-1:0] B2B_EXP =
`ifdef WUW_SATURATE_EN
    {16'h8000, 16'h7FFF, 16'hFFFB};
`else
    {16'h7FFF, 16'h8000, 16'hFFFB};
`endif

  initial begin
    int p0, w0, r0, a0, n;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram[0]  = {16'h0003, 16'h0002, 16'h0001};
    ram[1]  = {16'h0010, 16'h0020, 16'h0030};
    ram[2]  = {16'h0000, 16'h0000, 16'h7F00};
    ram[5]  = {16'hFF00, 16'h0200, 16'h0100};
    ram[11] = {16'h0004, 16'h0004, 16'h0004};
    ram[15] = {16'h8000, 16'h7FFF, 16'h0000};
    for (int i = 0; i < 16; i++) gram[i] = ram[i];

    // Pin the model arithmetic by hand
    chk("model_ovf", W'(lane_res(16'h7F00, 16'h8100)), W'(OVF_EXP));
    chk("model_neg", W'(lane_res(16'hFF00, 16'h0100)), W'(16'hFE00));

    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_addr", W'(mem_addr), '0);
    chk("rst_wdata", mem_wr_data, '0);
    rst = 1'b0;

    // Idle
    a0 = active;
    repeat (20) @(negedge clk);
    chk("idle_activity", W'(active - a0), '0);

    // Single update to layer 1 row 1
    push(1, 1, {16'h0100, 16'h0200, 16'h0080});
    wait_done("single");
    chk("single_ram", ram[5], {16'hFE00, 16'h0000, 16'h0080});
    chk("single_count", W'(update_count), W'(16'd1));
    chk("single_addr", W'(last_pop_addr), W'(4'd5));
    chk("single_latency", W'(last_wr_e - last_pop_e), W'(2));

    // Back-to-back
    p0 = pops; w0 = wrs;
    push(0, 0, {16'h0001, 16'h0001, 16'h0001});
    push(0, 1, {16'hFFF0, 16'h0020, 16'h0010});
    push(3, 3, {16'h0001, 16'hFFFF, 16'h0005});
    wait_done("b2b");
    chk("b2b_pops", W'(pops - p0), W'(3));
    chk("b2b_writes", W'(wrs - w0), W'(3));
    chk("b2b_gap1", W'(pop_e[p0+1] - pop_e[p0]), W'(4));
    chk("b2b_gap2", W'(pop_e[p0+2] - pop_e[p0+1]), W'(4));
    chk("b2b_ram0", ram[0], {16'h0002, 16'h0001, 16'h0000});
    chk("b2b_ram1", ram[1], {16'h0020, 16'h0000, 16'h0020});
    chk("b2b_ram15", ram[15], B2B_EXP);
    chk("b2b_count", W'(update_count), W'(16'd4));

    // Out of range
    chk("err_before", W'(err_range), '0);
    p0 = pops; w0 = wrs; r0 = rds;
    push(4, 0, {16'h0001, 16'h0001, 16'h0001});
    push(0, 4, {16'h0001, 16'h0001, 16'h0001});
    wait_done("oor");
    chk("oor_pops", W'(pops - p0), W'(2));
    chk("oor_reads", W'(rds - r0), '0);
    chk("oor_writes", W'(wrs - w0), '0);
    chk("oor_err", W'(err_range), W'(1));
    chk("oor_count", W'(update_count), W'(16'd4));

    // Overflow lane
    push(0, 2, {16'h0000, 16'h0000, 16'h8100});
    wait_done("ovf");
    chk("ovf_ram", ram[2], {16'h0000, 16'h0000, OVF_EXP});
    chk("ovf_count", W'(update_count), W'(16'd5));

    // Reset during RDWAIT
    w0 = wrs;
    push(2, 3, {16'h0001, 16'h0001, 16'h0001});
    n = 0;
    while (!read_update_data && n < 50) begin @(negedge clk); n++; end
    chk("midrst_pop_seen", W'(read_update_data), W'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_count", W'(update_count), '0);
    chk("midrst_err", W'(err_range), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_nowrite", W'(wrs - w0), '0);
    chk("midrst_ram", ram[11], {16'h0004, 16'h0004, 16'h0004});
    push(2, 3, {16'h0001, 16'h0002, 16'h0003});
    wait_done("after_rst");
    chk("after_rst_ram", ram[11], {16'h0003, 16'h0002, 16'h0001});
    chk("after_rst_count", W'(update_count), W'(16'd1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
